// File: rtl/spi_rf_pkg.sv
// Shared frame geometry helpers and frame-state encoding for the SPI slave register file.
package spi_rf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    BURST
  } frame_state_e;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 11;
  localparam int DATA_LSB   = 0;

  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

  function automatic int rw_bit(input int addr_w, input int data_w);
    return frame_w(addr_w, data_w) - 1;
  endfunction

  function automatic int addr_lsb(input int data_w);
    return data_w;
  endfunction

  localparam int DEF_FRAME_W = 1 + DEF_ADDR_W + DEF_DATA_W;

endpackage

// File: rtl/spi_rf_ldb_edge.sv
// Synchronises the asynchronous active-low load strobe and emits a one-cycle pulse on its falling edge.
module spi_rf_ldb_edge #(
  parameter int LDB_SYNC = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ldb_i,
  output logic ld_pulse_o
);

  logic ldb_s;
  logic prev_q;

  if (LDB_SYNC > 0) begin : g_sync
    logic [LDB_SYNC-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sync_q <= '1;
      end else begin
        sync_q[0] <= ldb_i;
        for (int i = 1; i < LDB_SYNC; i++) begin
          sync_q[i] <= sync_q[i-1];
        end
      end
    end

    assign ldb_s = sync_q[LDB_SYNC-1];
  end else begin : g_nosync
    assign ldb_s = ldb_i;
  end

  // A strobe held low fires once: prev_q follows the level so only the transition counts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= ldb_s;
    end
  end

  assign ld_pulse_o = prev_q & ~ldb_s;

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI slave register file: per-channel writes, burst reads with auto-increment, and an
// all-channel sensor snapshot triggered by the load strobe.
module spi_slave_regfile
  import spi_rf_pkg::*;
#(
  parameter int NUM_CH   = 16,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int LDB_SYNC = 2,
  parameter int BURST_EN = 1
) (
  input  logic                     spi_clk,
  input  logic                     rst_n,
  input  logic                     csb,
  input  logic                     mosi,
  output logic                     miso,
  output logic                     miso_oe,
  input  logic                     ldb,
  input  logic [NUM_CH*DATA_W-1:0] sensor_data,
  output logic                     ld_done,
  output logic                     busy,
  output logic [7:0]               frame_err_cnt
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int RW_BIT  = rw_bit(ADDR_W, DATA_W);
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  frame_state_e      state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [FRAME_W-2:0] sr_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [DATA_W-1:0] sh_q;
  logic              oe_q;
  logic [7:0]        err_q;
  logic              ld_done_q;
  logic [DATA_W-1:0] rf_q [NUM_CH];

  logic [FRAME_W-1:0] frame_d;
  logic [ADDR_W-1:0]  addr_inc_d;
  logic [ADDR_W-1:0]  rd_sel_d;
  logic [DATA_W-1:0]  rd_word_d;
  logic               wr_commit_d;
  logic               ld_pulse;

  spi_rf_ldb_edge #(
    .LDB_SYNC(LDB_SYNC)
  ) u_ldb_edge (
    .clk_i     (spi_clk),
    .rst_ni    (rst_n),
    .ldb_i     (ldb),
    .ld_pulse_o(ld_pulse)
  );

  // frame_d is the frame as it stands including the bit being sampled this edge.
  assign frame_d    = {sr_q, mosi};
  assign addr_inc_d = (addr_q == ADDR_W'(NUM_CH - 1)) ? '0 : addr_q + 1'b1;
  assign rd_sel_d   = (state_q == ADDR) ? frame_d[ADDR_W-1:0] : addr_inc_d;
  assign wr_commit_d = !csb && (state_q == DATA) && !frame_d[RW_BIT]
                       && (cnt_q == CNT_W'(FRAME_W - 1));

  always_comb begin
    rd_word_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel_d == ADDR_W'(i)) rd_word_d = rf_q[i];
    end
  end

  // Snapshot has priority over a same-cycle write commit; out-of-range writes match no entry.
  always_ff @(posedge spi_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) rf_q[i] <= '0;
    end else if (ld_pulse) begin
      for (int i = 0; i < NUM_CH; i++) rf_q[i] <= sensor_data[i*DATA_W +: DATA_W];
    end else if (wr_commit_d) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (addr_q == ADDR_W'(i)) rf_q[i] <= frame_d[DATA_LSB +: DATA_W];
      end
    end
  end

  always_ff @(posedge spi_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      sh_q      <= '0;
      oe_q      <= 1'b0;
      err_q     <= '0;
      ld_done_q <= 1'b0;
    end else begin
      ld_done_q <= ld_pulse;
      if (csb) begin
        // A frame that never reached its last bit is an abort; completed bursts are not.
        if (state_q != IDLE && state_q != BURST && cnt_q != CNT_W'(FRAME_W) && err_q != 8'hFF) begin
          err_q <= err_q + 1'b1;
        end
        state_q <= IDLE;
        cnt_q   <= '0;
        oe_q    <= 1'b0;
        sh_q    <= '0;
      end else begin
        sr_q <= frame_d[FRAME_W-2:0];
        sh_q <= {sh_q[DATA_W-2:0], 1'b0};
        unique case (state_q)
          IDLE: begin
            state_q <= ADDR;
            cnt_q   <= CNT_W'(1);
          end
          ADDR: begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(ADDR_W)) begin
              state_q <= DATA;
              rw_q    <= frame_d[ADDR_W];
              addr_q  <= frame_d[ADDR_W-1:0];
              if (frame_d[ADDR_W]) begin
                sh_q <= rd_word_d;
                oe_q <= 1'b1;
              end
            end
          end
          DATA: begin
            if (cnt_q == CNT_W'(FRAME_W - 1)) begin
              if (rw_q && BURST_EN != 0) begin
                state_q <= BURST;
                cnt_q   <= CNT_W'(ADDR_W + 1);
                addr_q  <= addr_inc_d;
                sh_q    <= rd_word_d;
              end else begin
                cnt_q <= CNT_W'(FRAME_W);
                oe_q  <= 1'b0;
              end
            end else if (cnt_q != CNT_W'(FRAME_W)) begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          BURST: begin
            // The counter loops over the data slots so each pass streams one channel.
            if (cnt_q == CNT_W'(FRAME_W - 1)) begin
              cnt_q  <= CNT_W'(ADDR_W + 1);
              addr_q <= addr_inc_d;
              sh_q   <= rd_word_d;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign miso          = oe_q & sh_q[DATA_W-1];
  assign miso_oe       = oe_q;
  assign busy          = (state_q != IDLE);
  assign ld_done       = ld_done_q;
  assign frame_err_cnt = err_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Scoreboarded bench for spi_slave_regfile: a 16-channel instance and a 4-channel instance on one SPI bus.
module tb_spi_slave_regfile;

  localparam int DW  = 11;
  localparam int AW  = 4;
  localparam int NCH = 16;

  logic spi_clk = 1'b0;
  logic rst_n   = 1'b0;
  logic csb     = 1'b1;
  logic csb4    = 1'b1;
  logic mosi    = 1'b0;
  logic ldb     = 1'b1;
  logic [NCH*DW-1:0] sensor;
  logic [4*DW-1:0]   sensor4;
  logic miso, miso_oe, ld_done, busy;
  logic miso4, miso_oe4, ld_done4, busy4;
  logic [7:0] err, err4;

  always #5 spi_clk = ~spi_clk;

  spi_slave_regfile #(.NUM_CH(NCH), .DATA_W(DW), .ADDR_W(AW), .LDB_SYNC(2), .BURST_EN(1)) dut (
    .spi_clk(spi_clk), .rst_n(rst_n), .csb(csb), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
    .ldb(ldb), .sensor_data(sensor), .ld_done(ld_done), .busy(busy), .frame_err_cnt(err)
  );

  spi_slave_regfile #(.NUM_CH(4), .DATA_W(DW), .ADDR_W(AW), .LDB_SYNC(2), .BURST_EN(1)) dut4 (
    .spi_clk(spi_clk), .rst_n(rst_n), .csb(csb4), .mosi(mosi), .miso(miso4), .miso_oe(miso_oe4),
    .ldb(1'b1), .sensor_data(sensor4), .ld_done(ld_done4), .busy(busy4), .frame_err_cnt(err4)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int ld_cnt = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q4[$];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge spi_clk) if (ld_done === 1'b1) ld_cnt++;

  // Monitors: assemble DW-bit words from miso while the slave drives it.
  int nb0 = 0;
  logic [DW-1:0] acc0;
  always @(negedge spi_clk) begin
    if (!rst_n || csb || !miso_oe) nb0 = 0;
    else begin
      acc0 = {acc0[DW-2:0], miso};
      nb0++;
      if (nb0 == DW) begin
        nb0 = 0;
        if (q0.size() == 0) begin
          n_chk++;
          $display("FAIL rd_word: got %0h expected no word", acc0);
        end else check("rd_word", acc0, q0.pop_front());
      end
    end
  end

  int nb4 = 0;
  logic [DW-1:0] acc4;
  always @(negedge spi_clk) begin
    if (!rst_n || csb4 || !miso_oe4) nb4 = 0;
    else begin
      acc4 = {acc4[DW-2:0], miso4};
      nb4++;
      if (nb4 == DW) begin
        nb4 = 0;
        if (q4.size() == 0) begin
          n_chk++;
          $display("FAIL rd_word4: got %0h expected no word", acc4);
        end else check("rd_word4", acc4, q4.pop_front());
      end
    end
  end

  // Starts and ends at posedge+2; ldb is pulsed low for the one slot ldb_slot if it is >= 0.
  task automatic frame(input bit sel4, input logic [15:0] fr, input int nbits, input int ldb_slot);
    if (sel4) csb4 = 1'b0; else csb = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i < 16) mosi = fr[15-i]; else mosi = 1'b0;
      if (i == ldb_slot) ldb = 1'b0; else if (i == ldb_slot + 1) ldb = 1'b1;
      @(posedge spi_clk); #2;
    end
    csb = 1'b1; csb4 = 1'b1; mosi = 1'b0; ldb = 1'b1;
    @(posedge spi_clk); #2;
  endtask

  task automatic rd(input logic [3:0] a, input logic [DW-1:0] exp);
    q0.push_back(exp);
    frame(1'b0, {1'b1, a, 11'h000}, 16, -1);
  endtask

  task automatic rd4(input logic [3:0] a, input logic [DW-1:0] exp);
    q4.push_back(exp);
    frame(1'b1, {1'b1, a, 11'h000}, 16, -1);
  endtask

  task automatic wr(input bit sel4, input logic [3:0] a, input logic [DW-1:0] d);
    frame(sel4, {1'b0, a, d}, 16, -1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ld0;
    logic [15:0] rd0;
    sensor  = '0;
    sensor4 = '0;
    sensor[0*DW +: DW]  = 11'h7FF;
    sensor[1*DW +: DW]  = 11'h000;
    sensor[2*DW +: DW]  = 11'h555;
    sensor[3*DW +: DW]  = 11'h2AA;
    sensor[14*DW +: DW] = 11'h1E1;
    sensor[15*DW +: DW] = 11'h5A5;

    repeat (3) @(posedge spi_clk);
    #2;
    check("rst_miso", miso, 0);
    check("rst_miso_oe", miso_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_ld_done", ld_done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(posedge spi_clk); #2;
    rd(4'd3, 11'h000);

    // Snapshot then read back the first four channels.
    ld0 = ld_cnt;
    ldb = 1'b0;
    @(posedge spi_clk); #2;
    ldb = 1'b1;
    repeat (6) @(posedge spi_clk);
    #2;
    check("ld_done_once", ld_cnt - ld0, 1);
    rd(4'd0, 11'h7FF);
    rd(4'd1, 11'h000);
    rd(4'd2, 11'h555);
    rd(4'd3, 11'h2AA);

    wr(1'b0, 4'd5, 11'h123);
    rd(4'd5, 11'h123);
    wr(1'b1, 4'd5, 11'h456);
    rd4(4'd5, 11'h000);
    wr(1'b1, 4'd2, 11'h456);
    rd4(4'd2, 11'h456);

    // Snapshot lands on the same edge as the ch1 write commit.
    sensor[1*DW +: DW] = 11'h0AB;
    ld0 = ld_cnt;
    frame(1'b0, {1'b0, 4'd1, 11'h3CD}, 16, 13);
    repeat (2) @(posedge spi_clk);
    #2;
    check("ld_done_collide", ld_cnt - ld0, 1);
    rd(4'd1, 11'h0AB);
    rd(4'd5, 11'h000);

    // Burst from 14 wraps through 15 into 0 and 1.
    q0.push_back(11'h1E1);
    q0.push_back(11'h5A5);
    q0.push_back(11'h7FF);
    q0.push_back(11'h0AB);
    frame(1'b0, {1'b1, 4'd14, 11'h000}, 16 + 3*11, -1);
    check("err_after_burst", err, 0);

    frame(1'b0, {1'b0, 4'd2, 11'h7AB}, 7, -1);
    check("err_one", err, 1);
    rd(4'd2, 11'h555);
    for (int k = 2; k <= 300; k++) begin
      frame(1'b0, {1'b0, 4'd2, 11'h7AB}, 7, -1);
      if (k == 254) check("err_254", err, 254);
      if (k == 255) check("err_255", err, 255);
    end
    check("err_sat", err, 255);
    rd(4'd2, 11'h555);

    // Reset in the middle of a read of ch0.
    rd0 = {1'b1, 4'd0, 11'h000};
    csb = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mosi = rd0[15-i];
      @(posedge spi_clk); #2;
    end
    check("pre_rst_oe", miso_oe, 1);
    check("pre_rst_miso", miso, 1);
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_miso", miso, 0);
    check("mid_rst_oe", miso_oe, 0);
    csb = 1'b1;
    mosi = 1'b0;
    @(posedge spi_clk); #2;
    check("mid_rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge spi_clk); #2;
    check("post_rst_err", err, 0);
    rd(4'd0, 11'h000);
    rd(4'd14, 11'h000);
    check("post_rst_err_frames", err, 0);

    repeat (3) @(posedge spi_clk);
    #2;
    check("queue_drain", q0.size() + q4.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
